// File: rtl/frogger_pkg.sv
// Shared Frogger game types and constants, also used by the renderer for
// drawing the time bar and the hearts.
package frogger_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    LEVEL    = 3'd3,
    GAMEOVER = 3'd4
  } game_state_t;

  localparam int unsigned TIME_MAX   = 200;
  localparam int unsigned LIVES_INIT = 3;
  localparam int unsigned HOME_PTS   = 50;

  localparam int unsigned TIME_W  = 8;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned HOMES_W = 3;

  // Score addition that clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/frame_sec_divider.sv
// Divides frame_tick down to one sec_tick_c per game second; clear holds the
// count at zero.
module frame_sec_divider #(
  parameter int unsigned FRAMES_PER_SEC = 60
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic tick,
  output logic sec_tick_c
);

  localparam int unsigned DIV_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [DIV_W-1:0] frame_div;

  assign sec_tick_c = tick && (frame_div == DIV_W'(FRAMES_PER_SEC - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_div <= '0;
    end else if (clear) begin
      frame_div <= '0;
    end else if (tick) begin
      frame_div <= sec_tick_c ? '0 : frame_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger play sequencer: lives, time bar, score, home slots and respawn.
// Optional macro BONUS_TIME_EN adds half the remaining time bar to each home score.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned DEATH_FRAMES   = 30,
  parameter int unsigned HOMES          = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               collide,
  input  logic               home_reached,
  output game_state_t        state,
  output logic [LIVES_W-1:0] lives,
  output logic [TIME_W-1:0]  time_width,
  output logic [SCORE_W-1:0] score,
  output logic [HOMES_W-1:0] homes_filled,
  output logic               frog_respawn,
  output logic               game_over
);

  localparam int unsigned DTH_W = $clog2(DEATH_FRAMES + 1);

  game_state_t        state_d;
  logic [LIVES_W-1:0] lives_d;
  logic [TIME_W-1:0]  time_width_d;
  logic [SCORE_W-1:0] score_d;
  logic [HOMES_W-1:0] homes_d;
  logic               respawn_d;
  logic [DTH_W-1:0]   death_cnt, death_cnt_d;
  logic               start_prev;
  logic               sec_tick_c;
  logic               timeout_c;
  logic               home_take_c;
  logic [SCORE_W-1:0] home_inc_c;

  // Frame divider only runs while playing; a fresh life or home restarts it.
  frame_sec_divider #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_div (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      ((state != PLAY) || home_take_c),
    .tick       (frame_tick && (state == PLAY)),
    .sec_tick_c (sec_tick_c)
  );

  // The decrement happens first, so a bar reaching zero on this second kills.
  assign timeout_c   = sec_tick_c && (time_width <= TIME_W'(1));
  assign home_take_c = (state == PLAY) && home_reached && !collide && !timeout_c;

`ifdef BONUS_TIME_EN
  assign home_inc_c = SCORE_W'(HOME_PTS) + SCORE_W'(time_width >> 1);
`else
  assign home_inc_c = SCORE_W'(HOME_PTS);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      lives        <= LIVES_W'(LIVES_INIT);
      time_width   <= TIME_W'(TIME_MAX);
      score        <= '0;
      homes_filled <= '0;
      frog_respawn <= 1'b0;
      game_over    <= 1'b0;
      death_cnt    <= '0;
      start_prev   <= 1'b0;
    end else begin
      state        <= state_d;
      lives        <= lives_d;
      time_width   <= time_width_d;
      score        <= score_d;
      homes_filled <= homes_d;
      frog_respawn <= respawn_d;
      game_over    <= (state_d == GAMEOVER);
      death_cnt    <= death_cnt_d;
      start_prev   <= start_btn;
    end
  end

  always_comb begin
    state_d      = state;
    lives_d      = lives;
    time_width_d = time_width;
    score_d      = score;
    homes_d      = homes_filled;
    respawn_d    = 1'b0;
    death_cnt_d  = death_cnt;

    unique case (state)
      IDLE, GAMEOVER: begin
        // IDLE starts on level, GAMEOVER only on a fresh press.
        if (start_btn && ((state == IDLE) || !start_prev)) begin
          state_d      = PLAY;
          lives_d      = LIVES_W'(LIVES_INIT);
          time_width_d = TIME_W'(TIME_MAX);
          score_d      = '0;
          homes_d      = '0;
          respawn_d    = 1'b1;
        end
      end
      PLAY: begin
        if (sec_tick_c && (time_width != '0)) begin
          time_width_d = time_width - TIME_W'(1);
        end
        if (collide || timeout_c) begin
          state_d     = DYING;
          lives_d     = (lives == '0) ? '0 : lives - LIVES_W'(1);
          death_cnt_d = '0;
        end else if (home_reached) begin
          score_d = sat_add(score, home_inc_c);
          if (homes_filled == HOMES_W'(HOMES - 1)) begin
            state_d = LEVEL;
          end else begin
            homes_d      = homes_filled + HOMES_W'(1);
            time_width_d = TIME_W'(TIME_MAX);
            respawn_d    = 1'b1;
          end
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (death_cnt == DTH_W'(DEATH_FRAMES - 1)) begin
            death_cnt_d = '0;
            if (lives == '0) begin
              state_d = GAMEOVER;
            end else begin
              state_d      = PLAY;
              time_width_d = TIME_W'(TIME_MAX);
              respawn_d    = 1'b1;
            end
          end else begin
            death_cnt_d = death_cnt + DTH_W'(1);
          end
        end
      end
      LEVEL: begin
        state_d      = PLAY;
        homes_d      = '0;
        time_width_d = TIME_W'(TIME_MAX);
        respawn_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Scoreboard bench for frogger_game_ctrl: random and directed play checked
// against a frame-counting game model.
module tb_frogger_game_ctrl;
  import frogger_pkg::*;

  localparam int FPS    = 60;
  localparam int DEATHS = 30;
  localparam int NHOMES = 5;

  logic               Clk, Reset;
  logic               frame_tick, start_btn, collide, home_reached;
  game_state_t        state;
  logic [LIVES_W-1:0] lives;
  logic [TIME_W-1:0]  time_width;
  logic [SCORE_W-1:0] score;
  logic [HOMES_W-1:0] homes_filled;
  logic               frog_respawn, game_over;

  frogger_game_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .collide      (collide),
    .home_reached (home_reached),
    .state        (state),
    .lives        (lives),
    .time_width   (time_width),
    .score        (score),
    .homes_filled (homes_filled),
    .frog_respawn (frog_respawn),
    .game_over    (game_over)
  );

  typedef struct {
    int st; int lv; int tw; int sc; int hm; int rs; int go;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Game model: time bar derived from frames played since the last reload.
  int m_st, m_lives, m_frames, m_score, m_homes, m_dcnt, m_resp, m_prev;

  function automatic int m_tw();
    return int'(TIME_MAX) - m_frames / FPS;
  endfunction

  function automatic void m_reset();
    m_st = int'(IDLE); m_lives = int'(LIVES_INIT); m_frames = 0; m_score = 0;
    m_homes = 0; m_dcnt = 0; m_resp = 0; m_prev = 0;
  endfunction

  function automatic void m_reload();
    m_st = int'(PLAY); m_lives = int'(LIVES_INIT); m_frames = 0; m_score = 0;
    m_homes = 0; m_resp = 1;
  endfunction

  function automatic void m_step(input bit s, input bit ft, input bit c, input bit h);
    int bonus;
    bonus = 0;
`ifdef BONUS_TIME_EN
    bonus = m_tw() / 2;
`endif
    m_resp = 0;
    if (m_st == int'(IDLE)) begin
      if (s) m_reload();
    end else if (m_st == int'(PLAY)) begin
      if (ft) m_frames++;
      if (c || m_frames >= int'(TIME_MAX) * FPS) begin
        m_st = int'(DYING);
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_dcnt = 0;
      end else if (h) begin
        m_score = m_score + int'(HOME_PTS) + bonus;
        if (m_score > 65535) m_score = 65535;
        if (m_homes == NHOMES - 1) m_st = int'(LEVEL);
        else begin
          m_homes++; m_frames = 0; m_resp = 1;
        end
      end
    end else if (m_st == int'(DYING)) begin
      if (ft) begin
        m_dcnt++;
        if (m_dcnt == DEATHS) begin
          m_dcnt = 0;
          if (m_lives == 0) m_st = int'(GAMEOVER);
          else begin
            m_st = int'(PLAY); m_frames = 0; m_resp = 1;
          end
        end
      end
    end else if (m_st == int'(LEVEL)) begin
      m_st = int'(PLAY); m_homes = 0; m_frames = 0; m_resp = 1;
    end else begin
      if (s && !m_prev) m_reload();
    end
    m_prev = int'(s);
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.st = m_st; e.lv = m_lives; e.tw = m_tw(); e.sc = m_score;
    e.hm = m_homes; e.rs = m_resp; e.go = (m_st == int'(GAMEOVER)) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("state", int'(state), e.st);
    cmp("lives", int'(lives), e.lv);
    cmp("time_width", int'(time_width), e.tw);
    cmp("score", int'(score), e.sc);
    cmp("homes_filled", int'(homes_filled), e.hm);
    cmp("frog_respawn", int'(frog_respawn), e.rs);
    cmp("game_over", int'(game_over), e.go);
  endtask

  task automatic cyc(input bit s, input bit ft, input bit c, input bit h);
    @(negedge Clk);
    Reset = 1'b0; start_btn = s; frame_tick = ft; collide = c; home_reached = h;
    m_step(s, ft, c, h);
    exp_q.push_back(m_expect());
  endtask

  // Reset is asserted between edges, so its effect is checked immediately too.
  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Reset = 1'b1; start_btn = 0; frame_tick = 0; collide = 0; home_reached = 0;
      m_reset();
      if (i == 0) begin
        #1;
        check_all(m_expect());
      end
      exp_q.push_back(m_expect());
    end
  endtask

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin
    Reset = 1'b1; start_btn = 0; frame_tick = 0; collide = 0; home_reached = 0;
    m_reset();
    rst_cyc(2);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (60) cyc(0, 1, 0, 0);
    repeat (3) begin
      cyc(0, 0, 1, 0);
      repeat (DEATHS) cyc(0, 1, 0, 0);
    end
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 1);
    repeat (DEATHS) cyc(0, 1, 0, 0);
    repeat (NHOMES) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    repeat (int'(TIME_MAX) * FPS + 5) cyc(0, 1, 0, 0);
    repeat (DEATHS) cyc(0, 1, 0, 0);
    repeat (4000)
      cyc(($urandom % 64) == 0, ($urandom % 2) == 0, ($urandom % 150) == 0,
          ($urandom % 40) == 0);
    rst_cyc(1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (15) cyc(0, 1, 0, 0);
    rst_cyc(2);
    cyc(1, 0, 0, 0);
    repeat (1320) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
